// File: rtl/rm_lane_tracker_pkg.sv
// rm_lane_tracker_pkg: core widths plus the shared lane-tracker types (state, report status, lane record).
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  localparam int unsigned RM_STAGE_W = 8;
  localparam int unsigned RM_TIMER_W = 32;
  typedef enum logic [1:0] {RM_IDLE, RM_WAIT, RM_REPORT} rm_lane_state_e;
  typedef enum logic {RM_DONE, RM_TIMEOUT} rm_rpt_status_e;
  typedef struct packed {
    rm_lane_state_e            state;
    logic [RM_STAGE_W-1:0]     stage;
    logic [RM_TIMER_W-1:0]     timer;
    logic [riscv::VLEN-1:0]    pc;
  } rm_lane_rec_t;
endpackage

// File: rtl/rm_lane_tracker_fsm.sv
// rm_lane_fsm: one tracked lane (IDLE/WAIT stage/REPORT) with stage timer; ports: alloc/pc in, routed event hit, lane reset, report ack, timeout cfg, record and status out.
module rm_lane_fsm
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alloc_i,
  input  logic [riscv::VLEN-1:0] pc_i,
  input  logic                   event_i,
  input  logic                   lane_reset_i,
  input  logic                   rpt_ack_i,
  input  logic [TIMEOUT_W-1:0]   cfg_timeout_i,
  output rm_lane_rec_t           rec_o,
  output rm_rpt_status_e         status_o
);
  rm_lane_rec_t rec_q, rec_d;
  rm_rpt_status_e status_q, status_d;
  logic [TIMEOUT_W-1:0] timer;
  assign timer    = rec_q.timer[TIMEOUT_W-1:0];
  assign rec_o    = rec_q;
  assign status_o = status_q;
  always_comb begin
    rec_d    = rec_q;
    status_d = status_q;
    if (lane_reset_i) rec_d.state = RM_IDLE;
    else case (rec_q.state)
      RM_IDLE: if (alloc_i) begin
        rec_d.state = RM_WAIT;
        rec_d.stage = '0;
        rec_d.timer = '0;
        rec_d.pc    = pc_i;
      end
      RM_WAIT: if (event_i) begin
        rec_d.timer = '0;
        if (rec_q.stage == RM_STAGE_W'(NUM_EVENTS - 1)) begin
          rec_d.state = RM_REPORT;
          status_d    = RM_DONE;
        end else rec_d.stage = rec_q.stage + RM_STAGE_W'(1);
      end else if (cfg_timeout_i != '0 && timer == cfg_timeout_i - TIMEOUT_W'(1)) begin
        rec_d.state = RM_REPORT;
        status_d    = RM_TIMEOUT;
      end else if (!(&timer)) rec_d.timer = RM_TIMER_W'(timer + TIMEOUT_W'(1));
      RM_REPORT: if (rpt_ack_i) rec_d.state = RM_IDLE;
      default: rec_d.state = RM_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rec_q    <= '0;
      status_q <= RM_DONE;
    end else begin
      rec_q    <= rec_d;
      status_q <= status_d;
    end
  end
endmodule

// File: rtl/rm_lane_tracker.sv
// rm_lane_tracker: allocates matching instructions to lanes, routes stage events to the oldest waiting lane, arbitrates completion reports; ports: enq handshake + cfg, event_i/lane_reset_i in, lane_vector_o/event_drop_o and rpt handshake out.
module rm_lane_tracker
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned TIMEOUT_W  = 8,
  parameter int unsigned VLEN       = riscv::VLEN
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  enq_valid_i,
  output logic                                  enq_ready_o,
  input  logic [VLEN-1:0]                       enq_pc_i,
  input  logic [6:0]                            enq_opcode_i,
  input  logic [6:0]                            cfg_opcode_i,
  input  logic [6:0]                            cfg_opcode_mask_i,
  input  logic [TIMEOUT_W-1:0]                  cfg_timeout_i,
  input  logic [NUM_EVENTS-1:0]                 event_i,
  input  logic [NUM_LANES-1:0]                  lane_reset_i,
  output logic [NUM_EVENTS-1:0][NUM_LANES-1:0]  lane_vector_o,
  output logic [NUM_EVENTS-1:0]                 event_drop_o,
  output logic                                  rpt_valid_o,
  input  logic                                  rpt_ready_i,
  output logic [$clog2(NUM_LANES)-1:0]          rpt_lane_o,
  output logic [VLEN-1:0]                       rpt_pc_o,
  output logic                                  rpt_status_o
);
  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam int unsigned PW = riscv::VLEN;
  rm_lane_rec_t   rec [NUM_LANES];
  rm_rpt_status_e st  [NUM_LANES];
  logic [NUM_LANES-1:0][NUM_LANES-1:0] older_q, older_d;
  logic [NUM_EVENTS-1:0][NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] free, alloc, hit, rpt_set, rpt_oh, ack;
  logic [LW-1:0] sel, sel_oldest, hold_lane_q;
  logic hold_q, match;
  // older[i][j] set means lane i was allocated before lane j; oldest = member older than every other member
  function automatic logic [NUM_LANES-1:0] pick_oldest(input logic [NUM_LANES-1:0] s,
                                                       input logic [NUM_LANES-1:0][NUM_LANES-1:0] o);
    logic [NUM_LANES-1:0] r;
    r = s;
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = 0; j < NUM_LANES; j++)
        if (i != j && s[j] && !o[i][j]) r[i] = 1'b0;
    return r;
  endfunction
  assign match       = ((enq_opcode_i ^ cfg_opcode_i) & cfg_opcode_mask_i) == 7'd0;
  assign enq_ready_o = !match || (|free);
  assign alloc       = (enq_valid_i && match) ? free & (~free + NUM_LANES'(1)) : '0;
  always_comb begin
    free          = '0;
    rpt_set       = '0;
    elig          = '0;
    lane_vector_o = '0;
    event_drop_o  = '0;
    hit           = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      free[l]    = rec[l].state == RM_IDLE && !lane_reset_i[l];
      rpt_set[l] = rec[l].state == RM_REPORT;
      for (int e = 0; e < NUM_EVENTS; e++)
        elig[e][l] = rec[l].state == RM_WAIT && rec[l].stage == RM_STAGE_W'(e) && !lane_reset_i[l];
    end
    for (int e = 0; e < NUM_EVENTS; e++) begin
      lane_vector_o[e] = event_i[e] ? pick_oldest(elig[e], older_q) : '0;
      event_drop_o[e]  = event_i[e] && !(|elig[e]);
      hit              = hit | lane_vector_o[e];
    end
  end
  always_comb begin
    older_d = older_q;
    for (int a = 0; a < NUM_LANES; a++)
      if (alloc[a])
        for (int j = 0; j < NUM_LANES; j++) begin
          older_d[a][j] = 1'b0;
          older_d[j][a] = j != a;
        end
  end
  // a report left waiting stays on the same lane even if an older lane reaches REPORT meanwhile
  always_comb begin
    rpt_oh     = pick_oldest(rpt_set, older_q);
    sel_oldest = '0;
    for (int l = 0; l < NUM_LANES; l++) if (rpt_oh[l]) sel_oldest = LW'(l);
    sel = (hold_q && rpt_set[hold_lane_q]) ? hold_lane_q : sel_oldest;
    ack = '0;
    for (int l = 0; l < NUM_LANES; l++) ack[l] = rpt_valid_o && rpt_ready_i && sel == LW'(l);
  end
  assign rpt_valid_o  = |rpt_set;
  assign rpt_lane_o   = rpt_valid_o ? sel : '0;
  assign rpt_pc_o     = rpt_valid_o ? VLEN'(rec[sel].pc) : '0;
  assign rpt_status_o = rpt_valid_o && st[sel] == RM_TIMEOUT;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      older_q     <= '0;
      hold_q      <= 1'b0;
      hold_lane_q <= '0;
    end else begin
      older_q     <= older_d;
      hold_q      <= rpt_valid_o && !rpt_ready_i;
      hold_lane_q <= sel;
    end
  end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rm_lane_fsm #(.NUM_EVENTS(NUM_EVENTS), .TIMEOUT_W(TIMEOUT_W)) u_fsm (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .alloc_i       (alloc[l]),
      .pc_i          (PW'(enq_pc_i)),
      .event_i       (hit[l]),
      .lane_reset_i  (lane_reset_i[l]),
      .rpt_ack_i     (ack[l]),
      .cfg_timeout_i (cfg_timeout_i),
      .rec_o         (rec[l]),
      .status_o      (st[l])
    );
  end
endmodule

// File: tb/tb_rm_lane_tracker.sv
// tb_rm_lane_tracker: directed self-checking bench for rm_lane_tracker with hand-computed expectations.
module tb_rm_lane_tracker;
  logic clk = 1'b0, rst, enq_valid, enq_ready, rpt_valid, rpt_ready, rpt_status;
  logic [63:0] enq_pc, rpt_pc;
  logic [6:0] enq_opcode, cfg_opcode, cfg_mask;
  logic [7:0] cfg_timeout;
  logic [3:0] event_in, lane_reset, event_drop;
  logic [3:0][3:0] lane_vector;
  logic [1:0] rpt_lane;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rm_lane_tracker dut (
    .clk_i(clk), .rst_i(rst), .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_pc_i(enq_pc), .enq_opcode_i(enq_opcode), .cfg_opcode_i(cfg_opcode),
    .cfg_opcode_mask_i(cfg_mask), .cfg_timeout_i(cfg_timeout), .event_i(event_in),
    .lane_reset_i(lane_reset), .lane_vector_o(lane_vector), .event_drop_o(event_drop),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_lane_o(rpt_lane),
    .rpt_pc_o(rpt_pc), .rpt_status_o(rpt_status)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; enq_valid = 1'b0; event_in = '0; lane_reset = '0; rpt_ready = 1'b0; cfg_timeout = '0;
    step(); step();
    rst = 1'b0;
  endtask
  task automatic enq(input logic [63:0] pc);
    enq_valid = 1'b1; enq_pc = pc; enq_opcode = 7'h63;
    step();
    enq_valid = 1'b0;
  endtask
  initial begin
    cfg_opcode = 7'h63; cfg_mask = 7'h7F; enq_opcode = 7'h63; enq_pc = '0;
    do_reset();
    rst = 1'b1; event_in = 4'b1000; #1;
    check("rst_ready", enq_ready, 1); check("rst_rvalid", rpt_valid, 0);
    check("rst_rlane", rpt_lane, 0); check("rst_rpc", rpt_pc, 0); check("rst_rstat", rpt_status, 0);
    check("rst_drop", event_drop, 4'b1000); check("rst_vec", lane_vector, 0);
    rst = 1'b0; step();
    check("idle_drop", event_drop, 4'b1000); check("idle_vec", lane_vector, 0);
    event_in = '0;
    // single instruction walks all stages to DONE
    enq_valid = 1'b1; enq_pc = 64'h1000; #1;
    check("a_ready", enq_ready, 1);
    step(); enq_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      event_in = 4'(1 << e); #1;
      check($sformatf("a_vec%0d", e), lane_vector[e], 4'b0001);
      check($sformatf("a_drop%0d", e), event_drop, 0);
      step();
    end
    event_in = '0; #1;
    check("a_rvalid", rpt_valid, 1); check("a_rlane", rpt_lane, 0);
    check("a_rpc", rpt_pc, 64'h1000); check("a_rstat", rpt_status, 0);
    rpt_ready = 1'b1; step(); rpt_ready = 1'b0; #1;
    check("a_rdone", rpt_valid, 0);
    // full occupancy, lane 2 made oldest, its report frees it
    do_reset();
    enq(64'h100); enq(64'h200); enq(64'h300);
    lane_reset = 4'b0011; step(); lane_reset = '0;
    enq(64'h400); enq(64'h500); enq(64'h600);
    for (int e = 0; e < 4; e++) begin
      event_in = 4'(1 << e); #1;
      check($sformatf("b_vec%0d", e), lane_vector[e], 4'b0100);
      step();
    end
    event_in = '0; enq_valid = 1'b1; enq_pc = 64'h777; #1;
    check("b_full_ready", enq_ready, 0);
    check("b_rlane", rpt_lane, 2); check("b_rpc", rpt_pc, 64'h300);
    enq_opcode = 7'h13; #1;
    check("b_nomatch_ready", enq_ready, 1);
    enq_opcode = 7'h63; rpt_ready = 1'b1; #1;
    check("b_ack_same_ready", enq_ready, 0);
    step(); rpt_ready = 1'b0; #1;
    check("b_freed_ready", enq_ready, 1); check("b_rvalid_off", rpt_valid, 0);
    step(); #1;
    check("b_realloc_ready", enq_ready, 0);
    enq_valid = 1'b0;
    // age ordering and independent routing of distinct stages
    do_reset();
    enq(64'h10); enq(64'h20);
    lane_reset = 4'b0001; step(); lane_reset = '0;
    enq(64'h30);
    event_in = 4'b0001; #1;
    check("c_vec0_older", lane_vector[0], 4'b0010);
    step();
    event_in = 4'b0011; #1;
    check("c_vec0", lane_vector[0], 4'b0001); check("c_vec1", lane_vector[1], 4'b0010);
    check("c_drop", event_drop, 0);
    step(); event_in = '0;
    // timeout, and event winning at the timeout cycle
    do_reset();
    cfg_timeout = 8'd5;
    enq(64'hABC);
    repeat (4) step();
    check("d_no_early", rpt_valid, 0);
    step();
    check("d_to_valid", rpt_valid, 1); check("d_to_stat", rpt_status, 1); check("d_to_pc", rpt_pc, 64'hABC);
    rpt_ready = 1'b1; step(); rpt_ready = 1'b0;
    enq(64'hDEF);
    repeat (4) step();
    event_in = 4'b0001; #1;
    check("d_ev_vec", lane_vector[0], 4'b0001);
    step(); event_in = '0; #1;
    check("d_ev_wins", rpt_valid, 0);
    repeat (4) step();
    check("d_stage1_no_early", rpt_valid, 0);
    step();
    check("d_stage1_to", rpt_status, 1);
    cfg_timeout = '0;
    // lane reset overrides routing and handshake
    do_reset();
    enq(64'h55);
    lane_reset = 4'b0001; event_in = 4'b0001; rpt_ready = 1'b1; #1;
    check("e_drop", event_drop, 4'b0001); check("e_vec", lane_vector[0], 0); check("e_rvalid", rpt_valid, 0);
    step(); lane_reset = '0; rpt_ready = 1'b0; #1;
    check("e_idle_drop", event_drop, 4'b0001); check("e_ready", enq_ready, 1);
    event_in = 4'b1000; #1;
    check("f_drop", event_drop, 4'b1000); check("f_vec", lane_vector, 0);
    event_in = '0;
    // reset in flight discards a pending report
    enq(64'h99);
    for (int e = 0; e < 4; e++) begin event_in = 4'(1 << e); step(); end
    event_in = '0; #1;
    check("g_pending", rpt_valid, 1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    check("g_discard", rpt_valid, 0); check("g_ready", enq_ready, 1); check("g_rpc", rpt_pc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
